// File: rtl/addsub_serial_seq_pkg.sv
// Shared types and constants for the nibble-serial add/subtract sequencer.
// Holds the FSM state encoding, the slice width and the index-width helper.
package addsub_serial_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Nibble index width: clog2 of the nibble count, never less than one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/addsub_serial_seq_addsub4.sv
// Combinational 4-bit add/subtract slice built as a ripple of full adders.
// Subtract inverts b and the incoming carry, so carry_in acts as a borrow and carry_out as "no borrow".
module addsub4_structural
   import addsub_serial_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] i_a,
   input  logic [NIBBLE_W-1:0] i_b,
   input  logic                i_sub,
   input  logic                i_cin,
   output logic [NIBBLE_W-1:0] o_sum,
   output logic                o_cout
);

   logic [NIBBLE_W-1:0] w_b;
   logic [NIBBLE_W:0]   w_c;

   assign w_b    = i_b ^ {NIBBLE_W{i_sub}};
   assign w_c[0] = i_cin ^ i_sub;

   for (genvar g = 0; g < NIBBLE_W; g++) begin : g_fa
      assign o_sum[g]   = i_a[g] ^ w_b[g] ^ w_c[g];
      assign w_c[g+1]   = (i_a[g] & w_b[g]) | (w_c[g] & (i_a[g] ^ w_b[g]));
   end

   assign o_cout = w_c[NIBBLE_W];

endmodule

// File: rtl/addsub_serial_seq.sv
// Multi-cycle W-bit add/subtract sequencer: feeds latched operands through one 4-bit slice,
// LSB nibble first, carrying between nibbles and assembling the wide result.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for start; outputs hold last result
// ST_RUN  | one nibble per clock through the slice, busy=1
// ST_DONE | one-cycle done pulse; start here is accepted back-to-back
module addsub_serial_seq
   import addsub_serial_seq_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        i_start,
   input  logic                        i_subtract,
   input  logic                        i_carry_in,
   input  logic [NIBBLE_W*NIBBLES-1:0] i_a,
   input  logic [NIBBLE_W*NIBBLES-1:0] i_b,
   output logic                        o_busy,
   output logic                        o_done,
   output logic [NIBBLE_W*NIBBLES-1:0] o_result,
   output logic                        o_carry_out,
   output logic                        o_overflow
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = idx_width(NIBBLES);

   state_t              r_state;
   logic [IDX_W-1:0]    r_idx;
   logic [W-1:0]        r_a;
   logic [W-1:0]        r_b;
   logic                r_sub;
   logic                r_cin;
   logic                r_carry;
   logic [W-1:0]        r_result;
   logic                r_busy;
   logic                r_done;
   logic                r_cout;
   logic                r_ovf;

   logic [NIBBLE_W-1:0] w_slice_a;
   logic [NIBBLE_W-1:0] w_slice_b;
   logic [NIBBLE_W-1:0] w_slice_sum;
   logic                w_slice_cin;
   logic                w_slice_cout;
   logic                w_last;
   logic                w_ovf;

   assign w_slice_a = r_a[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
   assign w_slice_b = r_b[int'(r_idx)*NIBBLE_W +: NIBBLE_W];
   // The slice re-applies subtract to its carry input, so the raw carry is pre-inverted here.
   assign w_slice_cin = (r_idx == '0) ? r_cin : (r_carry ^ r_sub);
   assign w_last      = (r_idx == IDX_W'(NIBBLES-1));
   assign w_ovf       = (r_a[W-1] ~^ (r_b[W-1] ^ r_sub)) & (w_slice_sum[NIBBLE_W-1] ^ r_a[W-1]);

   addsub4_structural u_slice (
      .i_a    (w_slice_a),
      .i_b    (w_slice_b),
      .i_sub  (r_sub),
      .i_cin  (w_slice_cin),
      .o_sum  (w_slice_sum),
      .o_cout (w_slice_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_cin    <= 1'b0;
         r_carry  <= 1'b0;
         r_result <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               r_done <= 1'b0;
               if (i_start) begin
                  r_a     <= i_a;
                  r_b     <= i_b;
                  r_sub   <= i_subtract;
                  r_cin   <= i_carry_in;
                  r_idx   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_result[int'(r_idx)*NIBBLE_W +: NIBBLE_W] <= w_slice_sum;
               r_carry <= w_slice_cout;
               if (w_last) begin
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_cout  <= w_slice_cout;
                  r_ovf   <= w_ovf;
                  r_state <= ST_DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_result    = r_result;
   assign o_carry_out = r_cout;
   assign o_overflow  = r_ovf;

endmodule

// File: tb/tb_addsub_serial_seq.sv
// Scoreboard bench for addsub_serial_seq (NIBBLES=4): stimulus pushes expected results,
// a negedge monitor pops and compares whenever done is presented.
module tb_addsub_serial_seq;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         i_start;
   logic         i_subtract;
   logic         i_carry_in;
   logic [W-1:0] i_a;
   logic [W-1:0] i_b;
   logic         o_busy;
   logic         o_done;
   logic [W-1:0] o_result;
   logic         o_carry_out;
   logic         o_overflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
      string        tag;
   } exp_t;

   exp_t sb[$];

   addsub_serial_seq #(.NIBBLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_start     (i_start),
      .i_subtract  (i_subtract),
      .i_carry_in  (i_carry_in),
      .i_a         (i_a),
      .i_b         (i_b),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_result    (o_result),
      .o_carry_out (o_carry_out),
      .o_overflow  (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && o_done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
               e = sb.pop_front();
               check({e.tag, "_result"}, 32'(o_result), 32'(e.res));
               check({e.tag, "_cout"}, 32'(o_carry_out), 32'(e.cout));
               check({e.tag, "_ovf"}, 32'(o_overflow), 32'(e.ovf));
            end
         end
      end
   end

   task automatic push(input logic [W-1:0] res, input logic cout, input logic ovf, input string tag);
      exp_t e;
      e.res = res; e.cout = cout; e.ovf = ovf; e.tag = tag;
      sb.push_back(e);
   endtask

   // Called at a negedge; n0 = edges already elapsed since (and including) the accepting edge.
   task automatic wait_done(input string tag, input int n0);
      int n;
      n = n0;
      while (!o_done && n < 20) begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      check({tag, "_latency"}, 32'(n), 32'd5);
   endtask

   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic cin);
      @(negedge clk);
      i_a = a; i_b = b; i_subtract = sub; i_carry_in = cin; i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      i_a = ~a; i_b = ~b; i_subtract = ~sub; i_carry_in = ~cin;
   endtask

   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input logic cin, input logic [W-1:0] res, input logic cout,
                        input logic ovf, input string tag);
      push(res, cout, ovf, tag);
      launch(a, b, sub, cin);
      wait_done(tag, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n = 1'b0; i_start = 1'b0; i_subtract = 1'b0; i_carry_in = 1'b0;
      i_a = '0; i_b = '0;
      #1;
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_done), 32'd0);
      check("rst_result", 32'(o_result), 32'd0);
      check("rst_cout", 32'(o_carry_out), 32'd0);
      check("rst_ovf", 32'(o_overflow), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors: {a, b, sub, cin, result, carry_out, overflow}
      do_op(16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, "add_basic");
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
      do_op(16'h1000, 16'h0001, 1'b1, 1'b0, 16'h0FFF, 1'b1, 1'b0, "sub_borrow_chain");
      do_op(16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, "sub_under");
      do_op(16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, "sub_bin");
      do_op(16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0009, 1'b0, 1'b0, "add_cin");
      do_op(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");

      // Start pulsed while busy must be ignored.
      push(16'h3333, 1'b0, 1'b0, "ignore_first");
      launch(16'h1111, 16'h2222, 1'b0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      i_a = 16'hFFFF; i_b = 16'hFFFF; i_subtract = 1'b0; i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      wait_done("ignore_first", 3);
      repeat (8) @(negedge clk);
      check("ignore_idle_busy", 32'(o_busy), 32'd0);

      // Start held high through DONE: second op accepted back-to-back.
      push(16'h0100, 1'b0, 1'b0, "b2b_first");
      push(16'h3000, 1'b1, 1'b0, "b2b_second");
      @(negedge clk);
      i_a = 16'h00FF; i_b = 16'h0001; i_subtract = 1'b0; i_carry_in = 1'b0; i_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      i_a = 16'h4000; i_b = 16'h1000; i_subtract = 1'b1;
      wait_done("b2b_first", 1);
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      check("b2b_busy", 32'(o_busy), 32'd1);
      wait_done("b2b_second", 1);
      repeat (3) @(negedge clk);

      // Reset in the middle of RUN abandons the operation.
      launch(16'h1234, 16'h1111, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(o_busy), 32'd0);
      check("midrst_done", 32'(o_done), 32'd0);
      check("midrst_result", 32'(o_result), 32'd0);
      check("midrst_cout", 32'(o_carry_out), 32'd0);
      check("midrst_ovf", 32'(o_overflow), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (8) @(negedge clk);
      check("midrst_idle_busy", 32'(o_busy), 32'd0);
      do_op(16'hABCD, 16'h1234, 1'b0, 1'b0, 16'hBE01, 1'b0, 1'b0, "post_rst");

      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
